// File: rtl/ones_run_pkg.sv
// Shared types and defaults for the ones_run_ctrl word-serial run-of-ones counter.
package ones_run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int W_DEF       = 8;
    localparam int RUN_LEN_DEF = 3;

endpackage

// File: rtl/ones_run_det.sv
// Serial Mealy-style run detector: registered hit after RUN_LEN consecutive ones,
// overlapping runs counted, run state held while en is low.
module ones_run_det
    import ones_run_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    output logic hit
);

    localparam int RW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN - 1);

    logic [RW-1:0] run;

    // The run counter saturates one short of RUN_LEN; any further one is a hit.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            run <= '0;
            hit <= 1'b0;
        end else if (en) begin
            if (bit_in) begin
                if (run == RUN_MAX) begin
                    hit <= 1'b1;
                end else begin
                    run <= run + 1'b1;
                    hit <= 1'b0;
                end
            end else begin
                run <= '0;
                hit <= 1'b0;
            end
        end else begin
            hit <= 1'b0;
        end
    end

endmodule

// File: rtl/ones_run_ctrl.sv
// Accepts a W-bit word, shifts it MSB-first through ones_run_det and returns the hit count.
// Define ONES_RUN_CTRL_CARRY_EN to let run state carry across consecutive words.
module ones_run_ctrl
    import ones_run_pkg::*;
#(
    parameter  int W       = W_DEF,
    parameter  int RUN_LEN = RUN_LEN_DEF,
    localparam int CW      = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    localparam int BW = $clog2(W);

    state_t        state, state_next;
    logic [W-1:0]  sreg;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] hit_cnt;
    logic          accept;
    logic          det_en;
    logic          det_clr;
    logic          hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_count  = '0;
        busy       = 1'b1;
        det_en     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                det_en = 1'b1;
                if (bit_cnt == '0) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_count = hit_cnt;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ONES_RUN_CTRL_CARRY_EN
    assign det_clr = 1'b0;
`else
    assign det_clr = accept;
`endif

    // hit lags its bit by one cycle, so FLUSH collects the hit of the final bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
            hit_cnt <= '0;
        end else begin
            if (accept) begin
                sreg    <= in_data;
                bit_cnt <= BW'(W - 1);
                hit_cnt <= '0;
            end else if (state == SHIFT) begin
                sreg <= {sreg[W-2:0], 1'b0};
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
            if ((state == SHIFT || state == FLUSH) && hit) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end

    ones_run_det #(
        .RUN_LEN(RUN_LEN)
    ) u_det (
        .clk   (clk),
        .reset (reset),
        .en    (det_en),
        .clr   (det_clr),
        .bit_in(sreg[W-1]),
        .hit   (hit)
    );

endmodule

// File: tb/tb_ones_run_ctrl.sv
// Self-checking bench for ones_run_ctrl; expected counts come from a sliding-window run model.
module tb_ones_run_ctrl;

    localparam int W       = 8;
    localparam int RUN_LEN = 3;
    localparam int CW      = $clog2(W + 1);
`ifdef ONES_RUN_CTRL_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] out_count;

    int n_cmp     = 0;
    int n_err     = 0;
    int model_run = 0;

    always #5 clk = ~clk;

    ones_run_ctrl #(
        .W      (W),
        .RUN_LEN(RUN_LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .busy     (busy)
    );

    // Count of window positions where the trailing RUN_LEN bits seen so far are all ones.
    function automatic int model_hits(input logic [W-1:0] w);
        int hits = 0;
        if (!CARRY) model_run = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w[i]) model_run++;
            else model_run = 0;
            if (model_run >= RUN_LEN) hits++;
        end
        return hits;
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        model_run = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int delay, output int cnt, output int lat);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (delay) begin
            @(posedge clk); #1;
        end
        cnt       = int'(out_count);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_run = 0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (out_count !== '0) begin n_err++; $display("[TB] FAIL reset_out_count: got %0d expected 0", out_count); end
    endtask

    task automatic test_words();
        logic [W-1:0] words [5] = '{8'hFF, 8'hEE, 8'hF0, 8'h00, 8'hB6};
        int           exp_c [5] = '{6, 2, 2, 0, 0};
        int cnt, lat, m;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            m = model_hits(words[i]);
            send_word(words[i], 0, cnt, lat);
            n_cmp++; if (cnt !== exp_c[i]) begin n_err++; $display("[TB] FAIL word_%0h_count: got %0d expected %0d", words[i], cnt, exp_c[i]); end
            n_cmp++; if (cnt !== m) begin n_err++; $display("[TB] FAIL word_%0h_model: got %0d expected %0d", words[i], cnt, m); end
            n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL word_%0h_latency: got %0d expected 10", words[i], lat); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int m;
        do_reset();
        m = model_hits(8'hEE);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_out_valid[%0d]: got %0b expected 1", c, out_valid); end
            n_cmp++; if (int'(out_count) !== m) begin n_err++; $display("[TB] FAIL bp_out_count[%0d]: got %0d expected %0d", c, out_count, m); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready[%0d]: got %0b expected 0", c, in_ready); end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_release_in_ready: got %0b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2] = '{8'hFF, 8'h0E};
        int exp_c [2] = '{6, 1};
        int m [2];
        int got [$];
        int acc_cyc [$];
        int idx = 0;
        bit acc, res;
        do_reset();
        m[0] = model_hits(words[0]);
        m[1] = model_hits(words[1]);
        in_data   = words[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got.size() < 2; cyc++) begin
            acc = in_valid && in_ready;
            res = out_valid && out_ready;
            if (res) got.push_back(int'(out_count));
            if (acc) acc_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 2) in_data = words[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (got.size() !== 2) begin n_err++; $display("[TB] FAIL b2b_result_count: got %0d expected 2", got.size()); end
        for (int i = 0; i < got.size() && i < 2; i++) begin
            n_cmp++; if (got[i] !== exp_c[i]) begin n_err++; $display("[TB] FAIL b2b_word%0d_count: got %0d expected %0d", i, got[i], exp_c[i]); end
            n_cmp++; if (got[i] !== m[i]) begin n_err++; $display("[TB] FAIL b2b_word%0d_model: got %0d expected %0d", i, got[i], m[i]); end
        end
        n_cmp++;
        if (acc_cyc.size() !== 2) begin
            n_err++; $display("[TB] FAIL b2b_accepts: got %0d expected 2", acc_cyc.size());
        end else if (acc_cyc[1] - acc_cyc[0] !== W + 3) begin
            n_err++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], W + 3);
        end
    endtask

    task automatic test_carry();
        int cnt, lat, m0, m1;
`ifdef ONES_RUN_CTRL_CARRY_EN
        int exp1 = 2;
`else
        int exp1 = 0;
`endif
        do_reset();
        m0 = model_hits(8'h03);
        send_word(8'h03, 0, cnt, lat);
        n_cmp++; if (cnt !== 0) begin n_err++; $display("[TB] FAIL carry_first_count: got %0d expected 0", cnt); end
        n_cmp++; if (cnt !== m0) begin n_err++; $display("[TB] FAIL carry_first_model: got %0d expected %0d", cnt, m0); end
        m1 = model_hits(8'hC0);
        send_word(8'hC0, 1, cnt, lat);
        n_cmp++; if (cnt !== exp1) begin n_err++; $display("[TB] FAIL carry_second_count: got %0d expected %0d", cnt, exp1); end
        n_cmp++; if (cnt !== m1) begin n_err++; $display("[TB] FAIL carry_second_model: got %0d expected %0d", cnt, m1); end
    endtask

    task automatic test_reset_mid();
        int cnt, lat, m;
        int seen = 0;
        do_reset();
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL mid_busy_before_reset: got %0b expected 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_run = 0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL mid_in_ready: got %0b expected 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
        n_cmp++; if (out_count !== '0) begin n_err++; $display("[TB] FAIL mid_out_count: got %0d expected 0", out_count); end
        for (int c = 0; c < 15; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("[TB] FAIL mid_no_result: got %0d out_valid cycles expected 0", seen); end
        m = model_hits(8'h07);
        send_word(8'h07, 0, cnt, lat);
        n_cmp++; if (cnt !== 1) begin n_err++; $display("[TB] FAIL mid_next_count: got %0d expected 1", cnt); end
        n_cmp++; if (cnt !== m) begin n_err++; $display("[TB] FAIL mid_next_model: got %0d expected %0d", cnt, m); end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        int cnt, lat, m, d;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            w = W'($urandom);
            d = int'($urandom_range(0, 3));
            m = model_hits(w);
            send_word(w, d, cnt, lat);
            n_cmp++; if (cnt !== m) begin n_err++; $display("[TB] FAIL rand%0d_%0h_count: got %0d expected %0d", i, w, cnt, m); end
            n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL rand%0d_latency: got %0d expected 10", i, lat); end
        end
    endtask

    initial begin
        $display("[TB] start, carry mode %0b", CARRY);
        test_reset();
        test_words();
        test_backpressure();
        test_back_to_back();
        test_carry();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
